// File: rtl/led_pwm.sv
// led_pwm: PWM brightness/pattern generator for an active-low LED pin.
// Four modes: off, static dimming, blink and breathe. The mode and duty
// inputs are only looked at on a PWM period boundary, so the brightness seen
// by the comparator changes only between periods and the pin never glitches.
//
// Handshake-free block: there is no valid/ready pair. The only "event" the
// outside world sees is period_end, a one-clock pulse in the last clock of
// every PWM period; the level it presents alongside is the brightness used
// for that whole period.
module led_pwm #(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 390,
  parameter int STEP_PERIODS  = 4,
  parameter int BLINK_PERIODS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led_r,
  output logic [PWM_BITS-1:0] level,
  output logic                period_end,
  output logic [1:0]          act_mode
);

  // Counter widths; a count range of one still needs a one-bit register.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int STP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_PERIODS - 1);
  localparam logic [STP_W-1:0]    STP_LAST = STP_W'(STEP_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Timebase state
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick;
  logic                boundary;

  // Pattern engine state
  mode_e               act_mode_q;
  mode_e               mode_in;
  logic [PWM_BITS-1:0] level_q;
  logic [BLK_W-1:0]    blink_cnt_q;
  phase_e              phase_q;
  logic [STP_W-1:0]    step_cnt_q;
  dir_e                dir_q;

  // Breathe next-step values
  logic [PWM_BITS-1:0] br_level_d;
  dir_e                br_dir_d;
  logic                blink_wrap;
  logic                step_wrap;

  // Output register
  logic                led_r_q;

  assign mode_in = mode_e'(mode);

  // Prescaler tick, PWM counter advance and the period boundary.
  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    boundary  = tick && (pwm_cnt_q == LVL_MAX);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    // The PWM counter wraps from max to 0 by natural overflow.
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
  end

  // Timebase registers; reset restarts the period from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Next breathe level: reversal and the step are resolved together, so a
  // level sitting at an end moves one step back inward instead of overshooting.
  always_comb begin
    br_level_d = level_q;
    br_dir_d   = dir_q;
    if (dir_q == DIR_UP) begin
      if (level_q == LVL_MAX) begin
        br_dir_d   = DIR_DOWN;
        br_level_d = level_q - PWM_BITS'(1);
      end else begin
        br_level_d = level_q + PWM_BITS'(1);
      end
    end else begin
      if (level_q == '0) begin
        br_dir_d   = DIR_UP;
        br_level_d = level_q + PWM_BITS'(1);
      end else begin
        br_level_d = level_q - PWM_BITS'(1);
      end
    end
  end

  // Period-count wrap flags for blink and breathe pacing.
  always_comb begin
    blink_wrap = (blink_cnt_q == BLK_LAST);
    step_wrap  = (step_cnt_q == STP_LAST);
  end

  // Pattern FSM: at each boundary sample mode/duty and pick the next level.
  // level itself is the applied duty, so no separate duty shadow is kept.
  // Entering blink or breathe from another mode restarts that pattern;
  // re-sampling the same mode lets it continue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_mode_q  <= MODE_OFF;
      level_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= PH_ON;
      step_cnt_q  <= '0;
      dir_q       <= DIR_UP;
    end else if (boundary) begin
      act_mode_q <= mode_in;
      case (mode_in)
        MODE_OFF: begin
          level_q <= '0;
        end
        MODE_STATIC: begin
          level_q <= duty;
        end
        MODE_BLINK: begin
          if (act_mode_q != MODE_BLINK) begin
            blink_cnt_q <= '0;
            phase_q     <= PH_ON;
            level_q     <= duty;
          end else if (blink_wrap) begin
            blink_cnt_q <= '0;
            phase_q     <= (phase_q == PH_ON) ? PH_OFF : PH_ON;
            level_q     <= (phase_q == PH_ON) ? '0 : duty;
          end else begin
            blink_cnt_q <= blink_cnt_q + BLK_W'(1);
            level_q     <= (phase_q == PH_ON) ? duty : '0;
          end
        end
        MODE_BREATHE: begin
          if (act_mode_q != MODE_BREATHE) begin
            step_cnt_q <= '0;
            dir_q      <= DIR_UP;
            level_q    <= '0;
          end else if (step_wrap) begin
            step_cnt_q <= '0;
            dir_q      <= br_dir_d;
            level_q    <= br_level_d;
          end else begin
            step_cnt_q <= step_cnt_q + STP_W'(1);
          end
        end
        default: begin
          level_q <= '0;
        end
      endcase
    end
  end

  // Registered comparator: lit (low) while the PWM count is below level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r_q <= 1'b1;
    end else begin
      led_r_q <= ~(pwm_cnt_q < level_q);
    end
  end

  assign led_r      = led_r_q;
  assign level      = level_q;
  assign period_end = boundary;
  assign act_mode   = act_mode_q;

  // A period is at least two clocks long, so the pulse never repeats back to back.
  a_period_end_single : assert property (
    @(posedge clk) disable iff (!rst_n) period_end |=> !period_end);

  // level only moves on the edge that closes a period.
  a_level_stable : assert property (
    @(posedge clk) disable iff (!rst_n) !period_end |=> $stable(level));

endmodule

// File: tb/tb_led_pwm.sv
// tb_led_pwm: randomized self-checking bench for led_pwm.
// A reference model counts clocks to find period boundaries, samples the
// inputs there and pushes the expected level for the next period; a monitor
// pops on every DUT period_end and checks level, low time and period spacing.
module tb_led_pwm;

  localparam int PWM_BITS      = 4;
  localparam int PRESCALE      = 2;
  localparam int STEP_PERIODS  = 1;
  localparam int BLINK_PERIODS = 2;
  localparam int LMAX          = (1 << PWM_BITS) - 1;
  localparam int PER           = PRESCALE * (1 << PWM_BITS);

  // Clock / reset
  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] duty;
  logic                led_r;
  logic [PWM_BITS-1:0] level;
  logic                period_end;
  logic [1:0]          act_mode;

  always #5 clk = ~clk;

  led_pwm #(
    .PWM_BITS      (PWM_BITS),
    .PRESCALE      (PRESCALE),
    .STEP_PERIODS  (STEP_PERIODS),
    .BLINK_PERIODS (BLINK_PERIODS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .duty       (duty),
    .led_r      (led_r),
    .level      (level),
    .period_end (period_end),
    .act_mode   (act_mode)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected level per period
  logic [PWM_BITS-1:0] exp_q[$];
  int                  mcyc;
  int                  prev_m;
  int                  k;

  function automatic int model_level(input int m, input int d, input int kk);
    int s;
    int t;
    case (m)
      0: return 0;
      1: return d;
      2: return (((kk / BLINK_PERIODS) % 2) == 0) ? d : 0;
      default: begin
        // Triangle 0..LMAX..0 with each end held for one step.
        s = kk / STEP_PERIODS;
        t = s % (2 * LMAX);
        return (t <= LMAX) ? t : (2 * LMAX - t);
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcyc   = 0;
      prev_m = 0;
      k      = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else if (mcyc == PER - 1) begin
      mcyc = 0;
      if ((int'(mode) == prev_m) && (mode[1] == 1'b1)) k++;
      else k = 0;
      prev_m = int'(mode);
      exp_q.push_back(PWM_BITS'(model_level(int'(mode), int'(duty), k)));
    end else begin
      mcyc++;
    end
  end

  // Monitor: pops one expectation per DUT period_end.
  int                  gap;
  int                  low_cnt;
  bit                  pend;
  logic [PWM_BITS-1:0] pend_lvl;
  logic [PWM_BITS-1:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      gap     = 0;
      low_cnt = 0;
      pend    = 1'b0;
    end else begin
      gap++;
      if (led_r == 1'b0) low_cnt++;
      if (pend) begin
        // This sample reflects the last clock of the period just closed.
        check("low_time", low_cnt, PRESCALE * int'(pend_lvl));
        low_cnt = 0;
        pend    = 1'b0;
      end
      if (period_end) begin
        check("period_gap", gap, PER);
        gap = 0;
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("level", level, e);
          pend     = 1'b1;
          pend_lvl = e;
        end
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [1:0] m, input logic [PWM_BITS-1:0] d);
    @(negedge clk);
    mode = m;
    duty = d;
  endtask

  task automatic wait_periods(input int n);
    repeat (n * PER) @(negedge clk);
  endtask

  task automatic wait_mcyc(input int target);
    int n;
    n = 0;
    while (mcyc != target && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    check("wait_mcyc_timeout", (mcyc == target) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mode  = 2'b00;
    duty  = PWM_BITS'($urandom_range(0, LMAX));

    // 1. Reset and off
    repeat (3) begin
      @(negedge clk);
      check("rst_led_r", led_r, 1);
      check("rst_level", level, 0);
      check("rst_period_end", period_end, 0);
      check("rst_act_mode", act_mode, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_periods(3);

    // 2. Static duty 4
    drive(2'b01, 4'd4);
    wait_periods(3);

    // 3. Mid-period duty change 4 -> 12
    wait_mcyc(PER / 2);
    drive(2'b01, 4'd12);
    wait_periods(3);

    // 4. Breathe through more than a full triangle
    drive(2'b11, PWM_BITS'($urandom_range(0, LMAX)));
    wait_periods(34);

    // 5. Blink, detour through breathe, blink again from the on-phase
    drive(2'b10, 4'd15);
    wait_periods(6);
    drive(2'b11, 4'd15);
    wait_periods(2);
    drive(2'b10, 4'd15);
    wait_periods(5);

    // 6. Asynchronous reset in the lit part of a static duty-12 period
    drive(2'b01, 4'd12);
    wait_periods(2);
    wait_mcyc(5);
    check("pre_reset_led_r", led_r, 0);
    check("pre_reset_level", level, 12);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_led_r", led_r, 1);
    check("async_level", level, 0);
    check("async_act_mode", act_mode, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_act_mode", act_mode, 0);
    wait_periods(3);

    // 7. Random mode/duty changes at random instants, including boundary cycles
    repeat (25) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      mode = 2'($urandom_range(0, 3));
      duty = PWM_BITS'($urandom_range(0, LMAX));
    end
    wait_periods(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
